// File: rtl/subleq_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// subleq_mem_arbiter_pkg
// Shared types and helpers for the subleq memory arbiter.
//   arbState_e    : arbiter FSM state (2-bit encoding)
//   STREAK_WIDTH  : width of the consecutive-host-grant counter
//   nextArbState  : next-state function of the lock FSM
// ---------------------------------------------------------------------------
package subleq_mem_arbiter_pkg;

   localparam int STREAK_WIDTH = 4;

   typedef enum logic [1:0] {
      ARB_NORMAL = 2'd0,
      ARB_DRAIN  = 2'd1,
      ARB_LOCKED = 2'd2
   } arbState_e;

   // The lock sequence always passes through DRAIN for one cycle so that a
   // CPU read issued just before the lock request can still return its data
   // before the host is told it owns memory exclusively.
   function automatic arbState_e nextArbState(input arbState_e current,
                                              input logic      lockRequest);
      arbState_e next;
      next = ARB_NORMAL;
      case (current)
         ARB_NORMAL: next = lockRequest ? ARB_DRAIN  : ARB_NORMAL;
         ARB_DRAIN:  next = lockRequest ? ARB_LOCKED : ARB_NORMAL;
         ARB_LOCKED: next = lockRequest ? ARB_LOCKED : ARB_NORMAL;
         default:    next = ARB_NORMAL;
      endcase
      return next;
   endfunction

endpackage

// File: rtl/subleq_rd_return.sv
// ---------------------------------------------------------------------------
// subleq_rd_return
// Tracks the single outstanding memory read and steers the returned word to
// the port that issued it, one cycle after the grant.
//   clk, areset            : clock, synchronous active-high reset
//   memEn, memWe           : memory command issued this cycle
//   hostGnt                : 1 when the issued command belongs to the host
//   memRdata               : memory read data (valid the cycle after a read)
//   cpuRvalid, cpuRdata    : CPU read return
//   hostRvalid, hostRdata  : host read return
// ---------------------------------------------------------------------------
module subleq_rd_return
   import subleq_mem_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 areset,
   input  logic                 memEn,
   input  logic                 memWe,
   input  logic                 hostGnt,
   input  logic [WORD_SIZE-1:0] memRdata,
   output logic                 cpuRvalid,
   output logic [WORD_SIZE-1:0] cpuRdata,
   output logic                 hostRvalid,
   output logic [WORD_SIZE-1:0] hostRdata
);

   logic                 pending;
   logic                 ownerHost;
   logic [WORD_SIZE-1:0] cpuHold;
   logic [WORD_SIZE-1:0] hostHold;

   // Capture, at grant time, whether a read was issued and who issued it.
   // The hold registers remember the last word delivered to each port so a
   // port's rdata stays put while the other port is being served.
   always_ff @(posedge clk) begin
      if (areset) begin
         pending   <= 1'b0;
         ownerHost <= 1'b0;
         cpuHold   <= '0;
         hostHold  <= '0;
      end else begin
         pending   <= memEn && !memWe;
         ownerHost <= hostGnt;
         if (cpuRvalid) begin
            cpuHold <= memRdata;
         end
         if (hostRvalid) begin
            hostHold <= memRdata;
         end
      end
   end

   // The memory only presents its data during the cycle after the read, so
   // the owner sees mem_rdata directly in that cycle and the held copy after.
   always_comb begin
      cpuRvalid  = pending && !ownerHost;
      hostRvalid = pending && ownerHost;
      cpuRdata   = cpuRvalid  ? memRdata : cpuHold;
      hostRdata  = hostRvalid ? memRdata : hostHold;
   end

endmodule

// File: rtl/subleq_mem_arbiter.sv
// ---------------------------------------------------------------------------
// subleq_mem_arbiter
// Single-port memory arbiter between the subleq CPU and a host/debug port,
// with a host lock mode that freezes CPU memory traffic.
//   clk, areset                          : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata, cpu_gnt       : CPU request and same-cycle grant
//   cpu_rvalid, cpu_rdata                : CPU read return (1-cycle latency)
//   host_req/we/addr/wdata, host_gnt     : host request and same-cycle grant
//   host_rvalid, host_rdata              : host read return (1-cycle latency)
//   host_lock, host_locked               : lock request / lock acknowledged
//   mem_en/we/addr/wdata, mem_rdata      : single-port memory interface
// ---------------------------------------------------------------------------
module subleq_mem_arbiter
   import subleq_mem_arbiter_pkg::*;
#(
   parameter int WORD_SIZE      = 16,
   parameter int HOST_BURST_MAX = 4
) (
   input  logic                 clk,
   input  logic                 areset,

   input  logic                 cpu_req,
   input  logic                 cpu_we,
   input  logic [WORD_SIZE-1:0] cpu_addr,
   input  logic [WORD_SIZE-1:0] cpu_wdata,
   output logic                 cpu_gnt,
   output logic                 cpu_rvalid,
   output logic [WORD_SIZE-1:0] cpu_rdata,

   input  logic                 host_req,
   input  logic                 host_we,
   input  logic [WORD_SIZE-1:0] host_addr,
   input  logic [WORD_SIZE-1:0] host_wdata,
   output logic                 host_gnt,
   output logic                 host_rvalid,
   output logic [WORD_SIZE-1:0] host_rdata,

   input  logic                 host_lock,
   output logic                 host_locked,

   output logic                 mem_en,
   output logic                 mem_we,
   output logic [WORD_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   input  logic [WORD_SIZE-1:0] mem_rdata
);

   arbState_e               state;
   arbState_e               stateNext;
   logic [STREAK_WIDTH-1:0] hostStreak;
   logic                    streakFull;
   logic                    cpuEligible;
   logic                    hostEligible;

   // Grant decision. The CPU is shut out the very cycle host_lock rises so a
   // new CPU access can never slip in behind the lock request. When both
   // sides compete, the host wins until it has taken HOST_BURST_MAX grants
   // in a row, which bounds the CPU's wait.
   always_comb begin
      stateNext    = nextArbState(state, host_lock);
      streakFull   = (hostStreak == STREAK_WIDTH'(HOST_BURST_MAX));
      cpuEligible  = cpu_req && !areset && !host_lock && (state == ARB_NORMAL);
      hostEligible = host_req && !areset;
      cpu_gnt      = cpuEligible && (!hostEligible || streakFull);
      host_gnt     = hostEligible && !cpu_gnt;
   end

   // Memory command mux. An idle cycle drives all-zero fields so the memory
   // bus is quiet and easy to read in a trace.
   always_comb begin
      mem_en    = cpu_gnt | host_gnt;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_gnt) begin
         mem_we    = cpu_we;
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
      end else if (host_gnt) begin
         mem_we    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   // Host streak counter: counts host grants taken while the CPU is waiting.
   // Any cycle where the CPU is not waiting, or is served, restarts fairness.
   // It saturates rather than wraps, so a long lock period leaves the CPU
   // first in line once the lock is released.
   always_ff @(posedge clk) begin
      if (areset) begin
         hostStreak <= '0;
      end else if (cpu_gnt || !cpu_req) begin
         hostStreak <= '0;
      end else if (host_gnt && !streakFull) begin
         hostStreak <= hostStreak + STREAK_WIDTH'(1);
      end
   end

   // Lock FSM. host_locked is registered alongside the state so it reads as
   // "the arbiter is in LOCKED this cycle", two cycles after host_lock rises.
   always_ff @(posedge clk) begin
      if (areset) begin
         state       <= ARB_NORMAL;
         host_locked <= 1'b0;
      end else begin
         state       <= stateNext;
         host_locked <= (stateNext == ARB_LOCKED);
      end
   end

   subleq_rd_return #(
      .WORD_SIZE (WORD_SIZE)
   ) rdReturn (
      .clk        (clk),
      .areset     (areset),
      .memEn      (mem_en),
      .memWe      (mem_we),
      .hostGnt    (host_gnt),
      .memRdata   (mem_rdata),
      .cpuRvalid  (cpu_rvalid),
      .cpuRdata   (cpu_rdata),
      .hostRvalid (host_rvalid),
      .hostRdata  (host_rdata)
   );

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_subleq_mem_arbiter
// Self-checking bench for subleq_mem_arbiter: a table of per-cycle vectors
// (reset, single requesters, 12-cycle contention) followed by hand-written
// sequences for pipelined reads, lock with an in-flight read, unlock, and
// reset in the middle of a lock. A behavioural memory with one-cycle read
// latency sits on the memory port.
// ---------------------------------------------------------------------------
module tb_subleq_mem_arbiter;

   logic        clk;
   logic        areset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr, cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic [15:0] cpu_rdata;
   logic        host_req, host_we;
   logic [15:0] host_addr, host_wdata;
   logic        host_gnt, host_rvalid;
   logic [15:0] host_rdata;
   logic        host_lock, host_locked;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;

   int total;
   int bad;

   typedef struct {
      logic        rst;
      logic        cpuReq;
      logic        cpuWe;
      logic [15:0] cpuAddr;
      logic        hostReq;
      logic        hostWe;
      logic [15:0] hostAddr;
      logic [15:0] hostWdata;
      logic        hostLock;
      logic        expCpuGnt;
      logic        expHostGnt;
      logic        expMemWe;
      logic [15:0] expMemAddr;
      logic [15:0] expMemWdata;
      logic        expCpuRvalid;
      logic        expHostRvalid;
      logic        expLocked;
   } vec_t;

   vec_t vecs [19];

   subleq_mem_arbiter #(
      .WORD_SIZE      (16),
      .HOST_BURST_MAX (4)
   ) dut (
      .clk         (clk),
      .areset      (areset),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_gnt     (cpu_gnt),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_rdata   (cpu_rdata),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .host_lock   (host_lock),
      .host_locked (host_locked),
      .mem_en      (mem_en),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Background memory contents: a recognisable function of the address.
   function automatic logic [15:0] memInit(input logic [15:0] a);
      return a ^ 16'hC3C3;
   endfunction

   // Behavioural single-port memory with one-cycle read latency.
   logic [15:0] memArray [0:65535];

   initial begin
      for (int i = 0; i < 65536; i++) begin
         memArray[i] = memInit(16'(i));
      end
      mem_rdata = 16'h0000;
   end

   always @(posedge clk) begin
      if (mem_en === 1'b1) begin
         if (mem_we === 1'b1) begin
            memArray[mem_addr] <= mem_wdata;
         end else begin
            mem_rdata <= memArray[mem_addr];
         end
      end
   end

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   function automatic vec_t mkVec(input logic rst, input logic cReq, input logic cWe,
                                  input logic [15:0] cAddr, input logic hReq,
                                  input logic hWe, input logic [15:0] hAddr,
                                  input logic [15:0] hWdata, input logic lock,
                                  input logic eCpuGnt, input logic eHostGnt,
                                  input logic eMemWe, input logic [15:0] eMemAddr,
                                  input logic [15:0] eMemWdata, input logic eCpuRvalid,
                                  input logic eHostRvalid, input logic eLocked);
      vec_t v;
      v.rst = rst;            v.cpuReq = cReq;         v.cpuWe = cWe;
      v.cpuAddr = cAddr;      v.hostReq = hReq;        v.hostWe = hWe;
      v.hostAddr = hAddr;     v.hostWdata = hWdata;    v.hostLock = lock;
      v.expCpuGnt = eCpuGnt;  v.expHostGnt = eHostGnt; v.expMemWe = eMemWe;
      v.expMemAddr = eMemAddr; v.expMemWdata = eMemWdata;
      v.expCpuRvalid = eCpuRvalid; v.expHostRvalid = eHostRvalid;
      v.expLocked = eLocked;
      return v;
   endfunction

   task automatic applyStimulus(input logic rst, input logic cReq, input logic cWe,
                                input logic [15:0] cAddr, input logic [15:0] cWdata,
                                input logic hReq, input logic hWe,
                                input logic [15:0] hAddr, input logic [15:0] hWdata,
                                input logic lock);
      areset     = rst;
      cpu_req    = cReq;
      cpu_we     = cWe;
      cpu_addr   = cAddr;
      cpu_wdata  = cWdata;
      host_req   = hReq;
      host_we    = hWe;
      host_addr  = hAddr;
      host_wdata = hWdata;
      host_lock  = lock;
   endtask

   task automatic checkOutput(input string name, input logic [15:0] actual,
                              input logic [15:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Inputs change just after the rising edge; outputs are sampled mid-cycle.
   task automatic sampleCycle;
      @(negedge clk);
   endtask

   task automatic nextCycle;
      @(posedge clk);
      #1;
   endtask

   logic [11:0] cpuTurnBits;

   initial begin
      vec_t v;
      logic cTurn, prevC, prevH;
      total = 0;
      bad   = 0;

      // ---------------- vector table ----------------
      // Reset with both requests asserted: nothing may be granted.
      vecs[0] = mkVec(1,1,0,16'h0020, 1,0,16'h0030,16'h0000, 0,
                      0,0,0,16'h0000,16'h0000, 0,0,0);
      vecs[1] = vecs[0];
      // Idle after reset.
      vecs[2] = mkVec(0,0,0,16'h0020, 0,0,16'h0030,16'h0000, 0,
                      0,0,0,16'h0000,16'h0000, 0,0,0);
      // CPU alone: granted at once.
      vecs[3] = mkVec(0,1,0,16'h0020, 0,0,16'h0030,16'h0000, 0,
                      1,0,0,16'h0020,16'h0000, 0,0,0);
      // Host write alone: granted; CPU read from the previous cycle returns.
      vecs[4] = mkVec(0,0,0,16'h0020, 1,1,16'h0030,16'h7777, 0,
                      0,1,1,16'h0030,16'h7777, 1,0,0);
      // Idle: a write returns nothing.
      vecs[5] = mkVec(0,0,0,16'h0020, 0,0,16'h0030,16'h0000, 0,
                      0,0,0,16'h0000,16'h0000, 0,0,0);
      // 12 cycles of contention, expected grant pattern HHHHC HHHHC HH.
      cpuTurnBits = 12'b0000_1000_0100;
      prevC = 1'b0;
      prevH = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cTurn = cpuTurnBits[11-k];
         vecs[6+k] = mkVec(0,1,0,16'h0040, 1,0,16'h0050,16'h0000, 0,
                           cTurn, !cTurn, 0, cTurn ? 16'h0040 : 16'h0050, 16'h0000,
                           prevC, prevH, 0);
         prevC = cTurn;
         prevH = !cTurn;
      end
      // Idle: last contention grant was the host's read.
      vecs[18] = mkVec(0,0,0,16'h0040, 0,0,16'h0050,16'h0000, 0,
                       0,0,0,16'h0000,16'h0000, 0,1,0);

      // Initial reset before the table.
      applyStimulus(1,0,0,0,0, 0,0,0,0, 0);
      nextCycle();
      nextCycle();

      for (int i = 0; i < 19; i++) begin
         v = vecs[i];
         applyStimulus(v.rst, v.cpuReq, v.cpuWe, v.cpuAddr, 16'h0000,
                       v.hostReq, v.hostWe, v.hostAddr, v.hostWdata, v.hostLock);
         sampleCycle();
         checkOutput($sformatf("row%0d cpu_gnt", i),     16'(cpu_gnt),     16'(v.expCpuGnt));
         checkOutput($sformatf("row%0d host_gnt", i),    16'(host_gnt),    16'(v.expHostGnt));
         checkOutput($sformatf("row%0d mem_en", i),      16'(mem_en),      16'(v.expCpuGnt | v.expHostGnt));
         checkOutput($sformatf("row%0d mem_we", i),      16'(mem_we),      16'(v.expMemWe));
         checkOutput($sformatf("row%0d mem_addr", i),    mem_addr,         v.expMemAddr);
         checkOutput($sformatf("row%0d mem_wdata", i),   mem_wdata,        v.expMemWdata);
         checkOutput($sformatf("row%0d cpu_rvalid", i),  16'(cpu_rvalid),  16'(v.expCpuRvalid));
         checkOutput($sformatf("row%0d host_rvalid", i), 16'(host_rvalid), 16'(v.expHostRvalid));
         checkOutput($sformatf("row%0d host_locked", i), 16'(host_locked), 16'(v.expLocked));
         nextCycle();
      end

      // ---------------- pipelined reads ----------------
      applyStimulus(0, 0,0,16'h0000,16'h0000, 1,1,16'h0010,16'h1234, 0);
      sampleCycle();
      checkOutput("pipe host write gnt", 16'(host_gnt), 16'd1);
      checkOutput("pipe host write data", mem_wdata, 16'h1234);
      nextCycle();
      applyStimulus(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0);
      sampleCycle();
      checkOutput("pipe rd0 cpu_gnt", 16'(cpu_gnt), 16'd1);
      nextCycle();
      applyStimulus(0, 1,0,16'h0011,16'h0000, 0,0,16'h0000,16'h0000, 0);
      sampleCycle();
      checkOutput("pipe rd1 cpu_gnt", 16'(cpu_gnt), 16'd1);
      checkOutput("pipe rd0 cpu_rvalid", 16'(cpu_rvalid), 16'd1);
      checkOutput("pipe rd0 cpu_rdata", cpu_rdata, 16'h1234);
      checkOutput("pipe rd0 host_rvalid", 16'(host_rvalid), 16'd0);
      nextCycle();
      applyStimulus(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0);
      sampleCycle();
      checkOutput("pipe rd1 cpu_rvalid", 16'(cpu_rvalid), 16'd1);
      checkOutput("pipe rd1 cpu_rdata", cpu_rdata, memInit(16'h0011));
      checkOutput("pipe rd1 host_rvalid", 16'(host_rvalid), 16'd0);
      nextCycle();
      sampleCycle();
      checkOutput("pipe idle cpu_rvalid", 16'(cpu_rvalid), 16'd0);
      checkOutput("pipe cpu_rdata hold", cpu_rdata, memInit(16'h0011));
      checkOutput("pipe host_rdata hold", host_rdata, memInit(16'h0050));
      nextCycle();

      // ---------------- lock with in-flight CPU read ----------------
      applyStimulus(0, 1,0,16'h0010,16'h0000, 0,0,16'h0000,16'h0000, 0);
      sampleCycle();
      checkOutput("lock N cpu_gnt", 16'(cpu_gnt), 16'd1);
      nextCycle();
      applyStimulus(0, 1,0,16'h0011,16'h0000, 0,0,16'h0000,16'h0000, 1);
      sampleCycle();
      checkOutput("lock N+1 cpu_gnt", 16'(cpu_gnt), 16'd0);
      checkOutput("lock N+1 cpu_rvalid", 16'(cpu_rvalid), 16'd1);
      checkOutput("lock N+1 cpu_rdata", cpu_rdata, 16'h1234);
      checkOutput("lock N+1 host_locked", 16'(host_locked), 16'd0);
      nextCycle();
      sampleCycle();
      checkOutput("lock N+2 cpu_gnt", 16'(cpu_gnt), 16'd0);
      checkOutput("lock N+2 cpu_rvalid", 16'(cpu_rvalid), 16'd0);
      checkOutput("lock N+2 host_locked", 16'(host_locked), 16'd0);
      nextCycle();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1,0,16'h0011,16'h0000, 1,1,16'(16'h0060 + i),16'(16'hBEEF + i), 1);
         sampleCycle();
         checkOutput($sformatf("locked wr%0d host_gnt", i), 16'(host_gnt), 16'd1);
         checkOutput($sformatf("locked wr%0d cpu_gnt", i), 16'(cpu_gnt), 16'd0);
         checkOutput($sformatf("locked wr%0d host_locked", i), 16'(host_locked), 16'd1);
         checkOutput($sformatf("locked wr%0d mem_addr", i), mem_addr, 16'(16'h0060 + i));
         nextCycle();
      end
      applyStimulus(0, 1,0,16'h0011,16'h0000, 1,0,16'h0060,16'h0000, 1);
      sampleCycle();
      checkOutput("locked rd host_gnt", 16'(host_gnt), 16'd1);
      nextCycle();
      applyStimulus(0, 1,0,16'h0011,16'h0000, 0,0,16'h0000,16'h0000, 1);
      sampleCycle();
      checkOutput("locked rd host_rvalid", 16'(host_rvalid), 16'd1);
      checkOutput("locked rd host_rdata", host_rdata, 16'hBEEF);
      checkOutput("locked rd cpu_gnt", 16'(cpu_gnt), 16'd0);
      nextCycle();

      // ---------------- unlock with CPU waiting ----------------
      applyStimulus(0, 1,0,16'h0011,16'h0000, 1,0,16'h0061,16'h0000, 0);
      sampleCycle();
      checkOutput("unlock M host_gnt", 16'(host_gnt), 16'd1);
      checkOutput("unlock M cpu_gnt", 16'(cpu_gnt), 16'd0);
      checkOutput("unlock M host_locked", 16'(host_locked), 16'd1);
      nextCycle();
      applyStimulus(0, 1,0,16'h0011,16'h0000, 1,0,16'h0062,16'h0000, 0);
      sampleCycle();
      checkOutput("unlock M+1 host_locked", 16'(host_locked), 16'd0);
      checkOutput("unlock M+1 cpu_gnt", 16'(cpu_gnt), 16'd1);
      checkOutput("unlock M+1 host_gnt", 16'(host_gnt), 16'd0);
      checkOutput("unlock M+1 mem_addr", mem_addr, 16'h0011);
      checkOutput("unlock M+1 host_rvalid", 16'(host_rvalid), 16'd1);
      checkOutput("unlock M+1 host_rdata", host_rdata, 16'hBEF0);
      nextCycle();
      applyStimulus(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0);
      sampleCycle();
      checkOutput("unlock M+2 cpu_rvalid", 16'(cpu_rvalid), 16'd1);
      checkOutput("unlock M+2 cpu_rdata", cpu_rdata, memInit(16'h0011));
      nextCycle();

      // ---------------- reset in the middle of a lock ----------------
      applyStimulus(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 1);
      sampleCycle();
      checkOutput("rstlock L0 host_locked", 16'(host_locked), 16'd0);
      nextCycle();
      sampleCycle();
      checkOutput("rstlock L1 host_locked", 16'(host_locked), 16'd0);
      nextCycle();
      applyStimulus(0, 0,0,16'h0000,16'h0000, 1,0,16'h0060,16'h0000, 1);
      sampleCycle();
      checkOutput("rstlock L2 host_locked", 16'(host_locked), 16'd1);
      checkOutput("rstlock L2 host_gnt", 16'(host_gnt), 16'd1);
      nextCycle();
      applyStimulus(1, 1,0,16'h0020,16'h0000, 1,0,16'h0060,16'h0000, 1);
      sampleCycle();
      checkOutput("rstlock R host_gnt", 16'(host_gnt), 16'd0);
      checkOutput("rstlock R cpu_gnt", 16'(cpu_gnt), 16'd0);
      checkOutput("rstlock R mem_en", 16'(mem_en), 16'd0);
      nextCycle();
      applyStimulus(0, 1,0,16'h0020,16'h0000, 0,0,16'h0000,16'h0000, 1);
      sampleCycle();
      checkOutput("rstlock A0 host_locked", 16'(host_locked), 16'd0);
      checkOutput("rstlock A0 cpu_gnt", 16'(cpu_gnt), 16'd0);
      checkOutput("rstlock A0 host_rvalid", 16'(host_rvalid), 16'd0);
      checkOutput("rstlock A0 host_rdata", host_rdata, 16'h0000);
      checkOutput("rstlock A0 cpu_rdata", cpu_rdata, 16'h0000);
      nextCycle();
      sampleCycle();
      checkOutput("rstlock A1 host_locked", 16'(host_locked), 16'd0);
      nextCycle();
      sampleCycle();
      checkOutput("rstlock A2 host_locked", 16'(host_locked), 16'd1);
      checkOutput("rstlock A2 cpu_gnt", 16'(cpu_gnt), 16'd0);
      nextCycle();
      applyStimulus(0, 1,0,16'h0020,16'h0000, 0,0,16'h0000,16'h0000, 0);
      sampleCycle();
      checkOutput("rstlock U0 host_locked", 16'(host_locked), 16'd1);
      checkOutput("rstlock U0 cpu_gnt", 16'(cpu_gnt), 16'd0);
      nextCycle();
      sampleCycle();
      checkOutput("rstlock U1 host_locked", 16'(host_locked), 16'd0);
      checkOutput("rstlock U1 cpu_gnt", 16'(cpu_gnt), 16'd1);
      nextCycle();

      applyStimulus(0, 0,0,16'h0000,16'h0000, 0,0,16'h0000,16'h0000, 0);
      nextCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
